// File: rtl/wasm_frame_ctrl_pkg.sv
// Shared widths, error codes and FSM state type for the call/return frame sequencer.
package wasm_frame_ctrl_pkg;

  localparam int unsigned ST_WIDTH      = 32;
  localparam int unsigned ST_LOG2_DEPTH = 6;
  localparam int unsigned ST_PTR_W      = ST_LOG2_DEPTH + 1;

  typedef enum logic [1:0] {
    FC_ERR_OK    = 2'd0,
    FC_ERR_FRAME = 2'd1,
    FC_ERR_POP   = 2'd2,
    FC_ERR_PUSH  = 2'd3
  } fc_err_e;

  typedef enum logic [2:0] {
    FC_IDLE,
    FC_ZERO,
    FC_RET_RD,
    FC_RET_WR,
    FC_DONE
  } fc_state_e;

  // Params plus extra locals, kept 9 bits wide so 255+255 does not wrap.
  function automatic logic [8:0] frame_nlocals(input logic [7:0] param_num,
                                               input logic [7:0] local_num);
    return {1'b0, param_num} + {1'b0, local_num};
  endfunction

endpackage

// File: rtl/wasm_frame_ctrl_lifo.sv
// Frame LIFO: registered storage, only the occupancy pointer is reset.
module wasm_frame_lifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;
  assign top_o   = mem_q[AW'(cnt_q - CW'(1))];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[AW'(cnt_q)] <= data_i;
    end
  end

endmodule

// File: rtl/wasm_frame_ctrl.sv
// Call/return sequencer: owns the operand-stack command port while busy,
// zero-fills callee locals on call and restores the caller stack on return.
module wasm_frame_ctrl
  import wasm_frame_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_DEPTH = 16,
  parameter int unsigned PC_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic                     req_is_ret,
  input  logic [PC_WIDTH-1:0]      req_ret_pc,
  input  logic [7:0]               req_param_num,
  input  logic [7:0]               req_local_num,
  input  logic                     req_result,
  output logic                     done_vld,
  output logic [1:0]               done_err,
  output logic [PC_WIDTH-1:0]      done_ret_pc,
  output logic                     fc_busy,
  input  logic [ST_PTR_W-1:0]      st_top,
  input  logic [ST_WIDTH-1:0]      st_window_a,
  input  logic                     st_exceed_push,
  output logic                     st_shift_vld,
  output logic                     st_push_num,
  output logic [3:0]               st_pop_num,
  output logic [ST_WIDTH-1:0]      st_push_data,
  output logic                     st_retu,
  output logic [ST_LOG2_DEPTH-1:0] st_func_tag,
  input  logic [7:0]               loc_idx,
  output logic [ST_PTR_W-1:0]      loc_addr,
  output logic                     loc_oob
);

  typedef struct packed {
    logic [ST_PTR_W-1:0] base;
    logic [PC_WIDTH-1:0] ret_pc;
    logic [8:0]          nlocals;
    logic                result;
  } frame_t;

  fc_state_e           state_q, state_d;
  fc_err_e             err_q, err_d;
  logic                is_ret_q, is_ret_d;
  logic                result_q, result_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [8:0]          nl_q, nl_d;
  logic [ST_PTR_W-1:0] base_q, base_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ST_WIDTH-1:0] res_q, res_d;

  logic   lifo_push, lifo_pop, lifo_full, lifo_empty;
  frame_t lifo_top, lifo_wr;

  assign lifo_wr = '{base: base_q, ret_pc: pc_q, nlocals: nl_q, result: result_q};

  wasm_frame_lifo #(
    .DEPTH (FRAME_DEPTH),
    .W     ($bits(frame_t))
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lifo_push),
    .pop_i   (lifo_pop),
    .data_i  (lifo_wr),
    .top_o   (lifo_top),
    .full_o  (lifo_full),
    .empty_o (lifo_empty)
  );

  assign fc_busy    = (state_q != FC_IDLE);
  assign st_pop_num = '0;
  assign loc_addr   = lifo_empty ? '0 : lifo_top.base + ST_PTR_W'(loc_idx);
  assign loc_oob    = lifo_empty || ({1'b0, loc_idx} >= lifo_top.nlocals);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FC_IDLE;
      err_q    <= FC_ERR_OK;
      is_ret_q <= 1'b0;
      result_q <= 1'b0;
      pc_q     <= '0;
      nl_q     <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      is_ret_q <= is_ret_d;
      result_q <= result_d;
      pc_q     <= pc_d;
      nl_q     <= nl_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    is_ret_d     = is_ret_q;
    result_d     = result_q;
    pc_d         = pc_q;
    nl_d         = nl_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    req_rdy      = 1'b0;
    done_vld     = 1'b0;
    done_err     = '0;
    done_ret_pc  = '0;
    st_shift_vld = 1'b0;
    st_push_num  = 1'b0;
    st_push_data = '0;
    st_retu      = 1'b0;
    st_func_tag  = '0;
    lifo_push    = 1'b0;
    lifo_pop     = 1'b0;

    unique case (state_q)
      FC_IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) begin
          is_ret_d = req_is_ret;
          pc_d     = req_ret_pc;
          result_d = req_result;
          nl_d     = frame_nlocals(req_param_num, req_local_num);
          base_d   = ST_PTR_W'(8'(st_top) - req_param_num);
          cnt_d    = req_local_num;
          res_d    = '0;
          err_d    = FC_ERR_OK;
          if (req_is_ret) begin
            if (lifo_empty) begin
              err_d   = FC_ERR_FRAME;
              state_d = FC_DONE;
            end else begin
              state_d = FC_RET_RD;
            end
          end else if (lifo_full) begin
            err_d   = FC_ERR_FRAME;
            state_d = FC_DONE;
          end else if (8'(st_top) < req_param_num) begin
            err_d   = FC_ERR_POP;
            state_d = FC_DONE;
          end else begin
            state_d = (req_local_num == '0) ? FC_DONE : FC_ZERO;
          end
        end
      end

      // A push-overflow aborts the fill without committing the frame.
      FC_ZERO: begin
        if (st_exceed_push) begin
          err_d   = FC_ERR_PUSH;
          state_d = FC_DONE;
        end else begin
          st_shift_vld = 1'b1;
          st_push_num  = 1'b1;
          cnt_d        = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = FC_DONE;
          end
        end
      end

      FC_RET_RD: begin
        res_d   = st_window_a;
        state_d = FC_RET_WR;
      end

      // pc_q is reused to carry the popped frame's return PC into DONE.
      FC_RET_WR: begin
        st_shift_vld = 1'b1;
        st_retu      = 1'b1;
        st_func_tag  = lifo_top.base[ST_LOG2_DEPTH-1:0];
        st_push_num  = lifo_top.result;
        st_push_data = res_q;
        lifo_pop     = 1'b1;
        pc_d         = lifo_top.ret_pc;
        state_d      = FC_DONE;
      end

      FC_DONE: begin
        done_vld = 1'b1;
        done_err = err_q;
        if (err_q == FC_ERR_OK) begin
          if (is_ret_q) begin
            done_ret_pc = pc_q;
          end else begin
            lifo_push = 1'b1;
          end
        end
        state_d = FC_IDLE;
      end

      default: state_d = FC_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wasm_frame_ctrl.sv
// Bench for wasm_frame_ctrl: operand-stack environment, transaction-level frame model,
// per-cycle output script comparison, directed scenarios and a randomized phase.
module tb_wasm_frame_ctrl;
  import wasm_frame_ctrl_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld, req_rdy, req_is_ret, req_result;
  logic [15:0] req_ret_pc;
  logic [7:0]  req_param_num, req_local_num;
  logic        done_vld;
  logic [1:0]  done_err;
  logic [15:0] done_ret_pc;
  logic        fc_busy;
  logic [6:0]  st_top;
  logic [31:0] st_window_a;
  logic        st_exceed_push;
  logic        st_shift_vld, st_push_num, st_retu;
  logic [3:0]  st_pop_num;
  logic [31:0] st_push_data;
  logic [5:0]  st_func_tag;
  logic [7:0]  loc_idx;
  logic [6:0]  loc_addr;
  logic        loc_oob;

  wasm_frame_ctrl #(.FRAME_DEPTH(DEPTH), .PC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_is_ret(req_is_ret),
    .req_ret_pc(req_ret_pc), .req_param_num(req_param_num), .req_local_num(req_local_num),
    .req_result(req_result), .done_vld(done_vld), .done_err(done_err), .done_ret_pc(done_ret_pc),
    .fc_busy(fc_busy), .st_top(st_top), .st_window_a(st_window_a), .st_exceed_push(st_exceed_push),
    .st_shift_vld(st_shift_vld), .st_push_num(st_push_num), .st_pop_num(st_pop_num),
    .st_push_data(st_push_data), .st_retu(st_retu), .st_func_tag(st_func_tag),
    .loc_idx(loc_idx), .loc_addr(loc_addr), .loc_oob(loc_oob)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int last_err = -1;
  int last_pc = -1;

  // Operand stack environment driven by the DUT command port and by bench pushes.
  logic [31:0] stk [64];
  int          sp = 0;
  logic        tb_push = 1'b0;
  logic [31:0] tb_push_data = '0;
  logic        tb_set = 1'b0;
  int          tb_set_val = 0;

  assign st_top      = 7'(sp);
  assign st_window_a = (sp > 0) ? stk[sp-1] : 32'h0;

  always @(posedge clk) begin : stack_env
    int t;
    if (st_shift_vld) begin
      t = st_retu ? int'(st_func_tag) : sp;
      if (st_push_num) begin
        stk[t] <= st_push_data;
        t = t + 1;
      end
      sp <= t;
    end else if (tb_set) begin
      sp <= tb_set_val;
    end else if (tb_push) begin
      stk[sp] <= tb_push_data;
      sp <= sp + 1;
    end
  end

  // Expected outputs per cycle, plus the open frames as the model sees them.
  typedef struct packed {
    logic        rdy;
    logic        busy;
    logic        shift;
    logic        push_num;
    logic [3:0]  pop;
    logic [31:0] data;
    logic        retu;
    logic [5:0]  tag;
    logic        done;
    logic [1:0]  err;
    logic [15:0] pc;
  } obs_t;

  typedef struct {
    int base;
    int ret_pc;
    int nlocals;
    int result;
  } frame_t;

  obs_t   script[$];
  frame_t frames[$];

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  function automatic obs_t busy_obs();
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic model_call(input int pc, input int param, input int local_n,
                            input int result, input int fail_at);
    obs_t   o;
    frame_t f;
    script.push_back(idle_obs());
    if (frames.size() == DEPTH || sp < param) begin
      o = busy_obs();
      o.done = 1'b1;
      o.err  = (frames.size() == DEPTH) ? 2'd1 : 2'd2;
      script.push_back(o);
      return;
    end
    for (int i = 0; i < local_n; i++) begin
      o = busy_obs();
      if (i == fail_at) begin
        script.push_back(o);
        o.done = 1'b1;
        o.err  = 2'd3;
        script.push_back(o);
        return;
      end
      o.shift    = 1'b1;
      o.push_num = 1'b1;
      script.push_back(o);
    end
    o = busy_obs();
    o.done = 1'b1;
    script.push_back(o);
    f.base    = sp - param;
    f.ret_pc  = pc;
    f.nlocals = param + local_n;
    f.result  = result;
    frames.push_back(f);
  endtask

  task automatic model_ret();
    obs_t   o;
    frame_t f;
    script.push_back(idle_obs());
    if (frames.size() == 0) begin
      o = busy_obs();
      o.done = 1'b1;
      o.err  = 2'd1;
      script.push_back(o);
      return;
    end
    f = frames.pop_back();
    script.push_back(busy_obs());
    o = busy_obs();
    o.shift    = 1'b1;
    o.retu     = 1'b1;
    o.tag      = 6'(f.base);
    o.push_num = 1'(f.result);
    o.data     = (sp > 0) ? stk[sp-1] : 32'h0;
    script.push_back(o);
    o = busy_obs();
    o.done = 1'b1;
    o.pc   = 16'(f.ret_pc);
    script.push_back(o);
  endtask

  always @(negedge clk) begin : compare
    obs_t e, a;
    bit   was_idle;
    int   ea;
    bit   eo;
    if (chk_en) begin
      was_idle = (script.size() == 0);
      e = was_idle ? idle_obs() : script.pop_front();
      a = '{rdy: req_rdy, busy: fc_busy, shift: st_shift_vld, push_num: st_push_num,
            pop: st_pop_num, data: st_push_data, retu: st_retu, tag: st_func_tag,
            done: done_vld, err: done_err, pc: done_ret_pc};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, a, e);
      end
      if (was_idle) begin
        if (frames.size() == 0) begin
          ea = 0;
          eo = 1'b1;
        end else begin
          ea = (frames[$].base + int'(loc_idx)) % 128;
          eo = (int'(loc_idx) >= frames[$].nlocals);
        end
        vectors++;
        if (loc_addr !== 7'(ea) || loc_oob !== eo) begin
          miscompares++;
          $display("FAIL loc_lookup t=%0t idx=%0d actual=%0d/%0b expected=%0d/%0b",
                   $time, loc_idx, loc_addr, loc_oob, ea, eo);
        end
      end
      if (done_vld) begin
        last_err = int'(done_err);
        last_pc  = int'(done_ret_pc);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input bit is_ret, input int pc, input int param, input int local_n,
                        input int result, input int fail_at);
    int idx;
    @(posedge clk); #1;
    if (is_ret) model_ret();
    else model_call(pc, param, local_n, result, fail_at);
    req_vld       = 1'b1;
    req_is_ret    = is_ret;
    req_ret_pc    = 16'(pc);
    req_param_num = 8'(param);
    req_local_num = 8'(local_n);
    req_result    = 1'(result);
    loc_idx       = 8'($urandom);
    @(posedge clk); #1;
    req_vld = 1'b0;
    idx = 0;
    while (script.size() > 0) begin
      st_exceed_push = (idx == fail_at);
      req_vld        = ($urandom_range(0, 3) == 0);
      req_is_ret     = 1'($urandom);
      req_param_num  = 8'($urandom);
      req_local_num  = 8'($urandom);
      loc_idx        = 8'($urandom);
      @(posedge clk); #1;
      idx++;
      if (idx > 400) begin
        vectors++;
        miscompares++;
        $display("FAIL request_timeout actual=%0d cycles expected<=400", idx);
        script.delete();
      end
    end
    st_exceed_push = 1'b0;
    req_vld        = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] val);
    @(posedge clk); #1;
    tb_push = 1'b1;
    tb_push_data = val;
    @(posedge clk); #1;
    tb_push = 1'b0;
  endtask

  task automatic do_set(input int val);
    @(posedge clk); #1;
    tb_set = 1'b1;
    tb_set_val = val;
    @(posedge clk); #1;
    tb_set = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pm, ln, fa, r;
    req_vld = 1'b0; req_is_ret = 1'b0; req_ret_pc = '0; req_param_num = '0;
    req_local_num = '0; req_result = 1'b0; st_exceed_push = 1'b0; loc_idx = 8'd3;
    rst = 1'b1;
    #1;
    chk("reset_rdy", int'(req_rdy), 1);
    chk("reset_busy", int'(fc_busy), 0);
    chk("reset_done", int'(done_vld), 0);
    chk("reset_shift", int'(st_shift_vld), 0);
    chk("reset_oob", int'(loc_oob), 1);
    chk("reset_addr", int'(loc_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Call into a frame with two params and three zero-filled locals.
    for (int i = 0; i < 5; i++) do_push(32'h100 + 32'(i));
    do_req(0, 16'h1234, 2, 3, 1, -1);
    chk("call_err", last_err, 0);
    chk("call_top", sp, 8);
    loc_idx = 8'd4; #1;
    chk("loc4_addr", int'(loc_addr), 7);
    chk("loc4_oob", int'(loc_oob), 0);
    loc_idx = 8'd5; #1;
    chk("loc5_oob", int'(loc_oob), 1);

    // Return one result value to the caller.
    do_push(32'hDEAD);
    do_req(1, 0, 0, 0, 0, -1);
    chk("ret_err", last_err, 0);
    chk("ret_pc", last_pc, 16'h1234);
    chk("ret_top", sp, 4);
    chk("ret_value", int'(stk[3]), 32'hDEAD);

    // Return with no result: stack drops back to the frame base.
    do_set(6);
    do_req(0, 16'h0042, 0, 0, 0, -1);
    for (int i = 0; i < 6; i++) do_push(32'(i));
    do_req(1, 0, 0, 0, 0, -1);
    chk("ret0_top", sp, 6);
    chk("ret0_pc", last_pc, 16'h0042);

    // Frame LIFO overflow on the seventeenth nested call, then unwind.
    for (int i = 0; i < DEPTH; i++) do_req(0, 16'h2000 + i, 0, 1, 0, -1);
    chk("nest_top", sp, 6 + DEPTH);
    do_req(0, 16'h3000, 0, 1, 0, -1);
    chk("nest_overflow_err", last_err, 1);
    for (int i = 0; i < DEPTH; i++) do_req(1, 0, 0, 0, 0, -1);
    chk("unwind_pc", last_pc, 16'h2000);
    chk("unwind_top", sp, 6);
    do_req(1, 0, 0, 0, 0, -1);
    chk("ret_empty_err", last_err, 1);

    // Parameter underflow and push overflow during zero-fill.
    do_set(2);
    do_req(0, 16'h0001, 4, 2, 0, -1);
    chk("param_underflow_err", last_err, 2);
    do_req(0, 16'h0002, 0, 4, 0, 1);
    chk("push_overflow_err", last_err, 3);
    chk("push_overflow_top", sp, 3);
    chk("push_overflow_oob", int'(loc_oob), 1);

    // Asynchronous reset in the middle of a zero-fill.
    do_req(0, 16'h0003, 1, 0, 0, -1);
    @(posedge clk); #1;
    chk_en = 1'b0;
    req_vld = 1'b1; req_is_ret = 1'b0; req_param_num = 8'd0; req_local_num = 8'd8;
    @(posedge clk); #1;
    req_vld = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_rdy", int'(req_rdy), 1);
    chk("midrst_busy", int'(fc_busy), 0);
    chk("midrst_shift", int'(st_shift_vld), 0);
    chk("midrst_oob", int'(loc_oob), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    frames.delete();
    script.delete();
    chk_en = 1'b1;
    do_req(1, 0, 0, 0, 0, -1);
    chk("midrst_lifo_empty", last_err, 1);
    do_set(10);

    // Randomized mix of calls, returns and callee pushes.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (sp > 45) begin
        if (frames.size() > 0) do_req(1, 0, 0, 0, 0, -1);
        else do_set(10);
      end else if (r < 4) begin
        pm = int'($urandom_range(0, (sp < 8) ? sp + 1 : 8));
        ln = int'($urandom_range(0, 5));
        fa = (ln > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, ln - 1)) : -1;
        do_req(0, int'($urandom_range(0, 65535)), pm, ln, int'($urandom_range(0, 1)), fa);
      end else if (r < 7) begin
        do_req(1, int'($urandom_range(0, 65535)), 0, 0, 0, -1);
      end else begin
        do_push($urandom);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
